multi_edge_detector: RTL



---
 rtl/multi_edge_detector.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/multi_edge_detector.sv
`default_nettype none
// ============================================================================
//  Module   : multi_edge_detector
//  Purpose  : Multi-channel edge detector. Each channel synchronises an
//             asynchronous input, detects rising/falling/both edges selected
//             at run time, and reports a one-cycle pulse, a sticky flag and a
//             saturating event counter.
//
//  Ports    : clk         - single clock, all state on the rising edge
//             reset       - asynchronous, active-high reset
//             data_in     - [WIDTH] asynchronous inputs, one per channel
//             mode        - [2] 00 off, 01 rising, 10 falling, 11 both
//             clear       - [WIDTH] per-channel synchronous clear of
//                           flag and counter
//             edge_pulse  - [WIDTH] one-cycle registered pulse per edge
//             edge_flag   - [WIDTH] sticky per-channel event flag
//             edge_count  - [WIDTH*CNT_W] flattened saturating counters,
//                           channel i at [i*CNT_W +: CNT_W]
//
//  Options  : DEBOUNCE_EN - when defined, a per-channel stability filter of
//             DEB_CYCLES clocks is inserted after the synchroniser.
//
//  Revision : 1.0 - initial release
// ============================================================================
module multi_edge_detector #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter bit INIT_VAL    = 1'b0,
    parameter int DEB_CYCLES  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       data_in,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       clear,
    output logic [WIDTH-1:0]       edge_pulse,
    output logic [WIDTH-1:0]       edge_flag,
    output logic [WIDTH*CNT_W-1:0] edge_count
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    // Elaboration-time parameter sanity checks.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("multi_edge_detector: WIDTH must be 1..32");
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("multi_edge_detector: SYNC_STAGES must be 2..4");
        end
        if (CNT_W < 1) begin : g_bad_cnt
            $error("multi_edge_detector: CNT_W must be at least 1");
        end
        if (DEB_CYCLES < 1) begin : g_bad_deb
            $error("multi_edge_detector: DEB_CYCLES must be at least 1");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic                   w_sampled;  // level that edges are detected on
            logic                   r_prev;
            logic                   w_rise;
            logic                   w_fall;
            logic                   w_det;
            logic                   r_pulse;
            logic                   r_flag;
            logic [CNT_W-1:0]       r_cnt;

            // Synchroniser: bit 0 takes the raw input, top bit is the safe copy.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sync <= {SYNC_STAGES{INIT_VAL}};
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], data_in[gi]};
                end
            end

`ifdef DEBOUNCE_EN
            // Counter runs 0..DEB_CYCLES-1; the filtered level flips on the
            // clock that would make DEB_CYCLES consecutive differing samples.
            localparam int c_DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
            localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);
            localparam logic [c_DEB_W-1:0] c_DEB_ONE  = c_DEB_W'(1);

            logic               r_filt;
            logic [c_DEB_W-1:0] r_deb_cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_filt    <= INIT_VAL;
                    r_deb_cnt <= '0;
                end else if (r_sync[SYNC_STAGES-1] == r_filt) begin
                    // Any return to the filtered level restarts the window.
                    r_deb_cnt <= '0;
                end else if (r_deb_cnt == c_DEB_LAST) begin
                    r_filt    <= r_sync[SYNC_STAGES-1];
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + c_DEB_ONE;
                end
            end

            assign w_sampled = r_filt;
`else
            assign w_sampled = r_sync[SYNC_STAGES-1];
`endif

            assign w_rise = w_sampled & ~r_prev;
            assign w_fall = ~w_sampled & r_prev;
            assign w_det  = (mode[0] & w_rise) | (mode[1] & w_fall);

            // History tracks the input even when mode is 00 so that enabling
            // detection later never reports a stale edge.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_prev  <= INIT_VAL;
                    r_pulse <= 1'b0;
                    r_flag  <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_prev  <= w_sampled;
                    r_pulse <= w_det;

                    // A new event beats a simultaneous clear.
                    if (w_det) begin
                        r_flag <= 1'b1;
                    end else if (clear[gi]) begin
                        r_flag <= 1'b0;
                    end

                    // Clear with a simultaneous event leaves exactly one count.
                    if (clear[gi]) begin
                        r_cnt <= w_det ? c_CNT_ONE : '0;
                    end else if (w_det && (r_cnt != c_CNT_MAX)) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
            end

            assign edge_pulse[gi]                 = r_pulse;
            assign edge_flag[gi]                  = r_flag;
            assign edge_count[gi*CNT_W +: CNT_W]  = r_cnt;
        end
    endgenerate

endmodule
`default_nettype wire
